// File: rtl/pipe_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock, 32 CALC cycles.
// Remainder feeds HI and quotient feeds LO; busy stalls the ID stage while CALC runs.
module pipe_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic [CNT_W-1:0] counter
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Operand magnitudes; 0x80000000 maps onto itself and is read as unsigned.
    always_comb begin
        dividend_mag = (sign && dividend[WIDTH-1]) ? WIDTH'(0) - dividend : dividend;
        divisor_mag  = (sign && divisor[WIDTH-1])  ? WIDTH'(0) - divisor  : divisor;
    end

    // One restoring step: shift {rem, quo} left, trial-subtract, MSB of trial is the borrow.
    always_comb begin
        trial    = {rem, quo[WIDTH-1]} - {1'b0, dvs};
        quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
        rem_next = trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
    end

    // Sign fixup; a zero divisor forces all-ones quotient, and the remainder
    // then naturally restores the original dividend.
    always_comb begin
        q_final = neg_q ? WIDTH'(0) - quo_next : quo_next;
        r_final = neg_r ? WIDTH'(0) - rem_next : rem_next;
        if (div_zero) begin
            q_final = '1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            counter  <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !flush) begin
                        state    <= CALC;
                        busy     <= 1'b1;
                        counter  <= '0;
                        rem      <= '0;
                        quo      <= dividend_mag;
                        dvs      <= divisor_mag;
                        neg_q    <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r    <= sign && dividend[WIDTH-1];
                        div_zero <= (divisor == '0);
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem     <= rem_next;
                        quo     <= quo_next;
                        counter <= counter + CNT_W'(1);
                        if (counter == LAST_ITER) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            q     <= q_final;
                            r     <= r_final;
                        end
                    end
                end
                DONE: begin
                    // Results are already committed, so flush and start are ignored here.
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_div_unit.sv
// Self-checking bench for pipe_div_unit: directed corners plus random operands
// against an arithmetic reference model of DIV/DIVU.
module tb_pipe_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic [5:0]  counter;

    int          errors;
    int          checks;
    logic [31:0] last_q;
    logic [31:0] last_r;

    pipe_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .flush    (flush),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .counter  (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the ISA's divide-by-zero and overflow results.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eq, output logic [31:0] er);
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = a;
        end else if (!s) begin
            eq = a / b;
            er = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            eq = 32'h8000_0000;
            er = 32'd0;
        end else begin
            eq = 32'($signed(a) / $signed(b));
            er = 32'($signed(a) % $signed(b));
        end
    endfunction

    // Issue one operation and follow it to done; returns at the done cycle's negedge.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int repulse_at, input bit start_at_done);
        logic [31:0] eq;
        logic [31:0] er;
        int          lat;
        int          nbusy;
        model(s, a, b, eq, er);
        @(negedge clk);
        sign = s; dividend = a; divisor = b; start = 1'b1;
        lat = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == repulse_at);
            if (start) sign = ~s;
            dividend = $urandom;
            divisor  = $urandom;
            if (busy) nbusy++;
        end while (!done && lat < 60);
        chk("latency", 32'(lat), 32'd33);
        chk("busy_cycles", 32'(nbusy), 32'd32);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("quotient", q, eq);
        chk("remainder", r, er);
        if (b != 32'd0) chk("identity", 32'(q * b + r), a);
        last_q = eq;
        last_r = er;
        if (start_at_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("start_at_done_ignored_a", 32'(busy), 32'd0);
            @(negedge clk);
            chk("start_at_done_ignored_b", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        bit          seen;
        errors = 0;
        checks = 0;
        rst = 1'b0;
        start = 1'b0;
        sign = 1'b0;
        flush = 1'b0;
        dividend = '0;
        divisor = '0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_q", q, 32'd0);
        chk("reset_r", r, 32'd0);
        chk("reset_counter", 32'(counter), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Unsigned
        run_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
        // Signed, all sign combinations of +-7 / +-2
        run_div(1'b1, 32'd7, 32'd2, 0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 1'b0);
        // Divide by zero and signed overflow
        run_div(1'b0, 32'h1234_5678, 32'd0, 0, 1'b0);
        run_div(1'b1, 32'h1234_5678, 32'd0, 0, 1'b0);
        run_div(1'b1, 32'h8765_4321, 32'd0, 0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        // start re-pulsed mid-CALC, then start held in the done cycle
        run_div(1'b0, 32'd12345, 32'd67, 5, 1'b0);
        run_div(1'b1, 32'hFFFF_F000, 32'd9, 0, 1'b1);

        // Flush at CALC cycle 10
        @(negedge clk);
        sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("counter_cycle10", 32'(counter), 32'd9);
        chk("busy_cycle10", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("busy_after_flush", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("quiet_after_flush", 32'(seen), 32'd0);
        chk("q_kept_after_flush", q, last_q);
        chk("r_kept_after_flush", r, last_r);

        // start together with flush in IDLE
        @(negedge clk);
        sign = 1'b1; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("start_flush_idle", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("start_flush_quiet", 32'(seen), 32'd0);

        // Random back-to-back operations
        for (int i = 0; i < 50; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) rb = 32'd0;
            run_div(rs, ra, rb, 0, 1'b0);
        end

        // Asynchronous reset mid-CALC
        @(negedge clk);
        sign = 1'b0; dividend = 32'd500; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_q", q, 32'd0);
        chk("midreset_r", r, 32'd0);
        chk("midreset_counter", 32'(counter), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
